enc_param_ctrl: RTL and testbench
=================================

ENC_PARAM_CTRL -- requirements
Module: enc_param_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a new button level.
REQ-002 Parameter PMAX, default 19: maximum value of every edited parameter; range is 0..PMAX.
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 step_inc  in  1  one-cycle clockwise detent pulse, clk-synchronous.
REQ-006 step_dec  in  1  one-cycle counter-clockwise detent pulse, clk-synchronous.
REQ-007 sel_btn  in  1  raw push button, asynchronous, active-high, bouncing.
REQ-008 upd_ack  in  1  display-side acknowledge of upd_req.
REQ-009 upd_req  out  1  display update request.
REQ-010 upd_idx  out  2  parameter index carried by the request.
REQ-011 upd_val  out  5  parameter value carried by the request.
REQ-012 sel_idx  out  2  currently selected parameter.
REQ-013 edit  out  1  high in EDIT mode.
REQ-014 param_bus  out  20  four 5-bit parameters, param n at bits [5n+4:5n].

Function
REQ-015 sel_btn SHALL pass a 2-flop synchronizer, then a debouncer changing its level only after DEBOUNCE_CYCLES consecutive equal samples; press = one-cycle pulse on debounced 0->1.
REQ-016 Mode FSM states: BROWSE, EDIT; press toggles BROWSE<->EDIT on the edge after the press pulse.
REQ-017 BROWSE: step_inc -> sel_idx+1 wrapping 3->0; step_dec -> sel_idx-1 wrapping 0->3.
REQ-018 EDIT: step_inc -> param[sel_idx]+1, PMAX wraps to 0; step_dec -> -1, 0 wraps to PMAX; other parameters unchanged.
REQ-019 Step and press SHALL be sampled on the same edge; the register changes on that edge (one-cycle latency).
REQ-020 step_inc and step_dec high together: no change, no dirty flag.
REQ-021 Press coincident with a step: press wins, step dropped.
REQ-022 Any change of sel_idx or of a parameter value, and any mode toggle, SHALL set a dirty flag.
REQ-023 Handshake FSM states: IDLE, REQ; IDLE with dirty -> REQ on next edge, latching upd_idx=sel_idx, upd_val=param[sel_idx], clearing dirty.
REQ-024 In REQ, upd_req, upd_idx, upd_val SHALL hold stable until upd_ack is sampled high; then upd_req low on that edge, return to IDLE.
REQ-025 Changes during REQ SHALL only set dirty; a new request follows at earliest one cycle after upd_req drops (upd_req low for at least one cycle between requests).
REQ-026 upd_ack while IDLE SHALL be ignored.

Reset
REQ-027 rst high SHALL immediately force: sel_idx=0, all parameters 0, mode BROWSE, edit=0, upd_req=0, upd_idx=0, upd_val=0, synchronizer, debouncer level and counter 0, handshake IDLE.
REQ-028 Dirty SHALL be 1 during reset, so upd_req rises on the second rising edge after rst deasserts with upd_idx=0, upd_val=0.
REQ-029 Reset asserted mid-handshake SHALL drop upd_req asynchronously; no pending update survives except REQ-028's.

Structure
REQ-030 Shared package enc_pkg SHALL hold: mode and handshake state enums, NUM_PARAMS=4, PARAM_W=5, IDX_W=2.
REQ-031 Debouncer (synchronizer + counter + edge detect) SHALL be sub-module btn_debounce; all else inside enc_param_ctrl.

Verification
REQ-032 Reset release, upd_ack tied to echo upd_req one cycle late -> single request idx=0 val=0, then upd_req stays low.
REQ-033 BROWSE, 5 step_inc pulses, acks returned -> sel_idx 0->1->2->3->0->1; final request idx=1 val=0.
REQ-034 sel_btn bounces 3 times under DEBOUNCE_CYCLES then holds high -> exactly one press, edit=1; three step_dec on param 1 -> values 19,18,17, param_bus[9:5]=17.
REQ-035 EDIT, param=19, step_inc -> 0; step_inc and step_dec high same cycle -> value unchanged, no new request.
REQ-036 upd_ack held low 20 cycles while 4 steps arrive -> upd_req/upd_idx/upd_val stable throughout; after ack exactly one follow-up request carrying the latest value.
REQ-037 rst asserted while upd_req high -> upd_req, param_bus, sel_idx zero without a clock edge; REQ-028 sequence repeats after release.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and sizing for the encoder-driven parameter editor.
package enc_pkg;
  localparam int unsigned NUM_PARAMS = 4;
  localparam int unsigned PARAM_W    = 5;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic {
    MODE_BROWSE = 1'b0,
    MODE_EDIT   = 1'b1
  } mode_e;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_REQ  = 1'b1
  } hs_e;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-sample debouncer and rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/enc_param_ctrl.sv
// Rotary-encoder parameter editor: browse/edit mode FSM plus display update handshake.
module enc_param_ctrl
  import enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PMAX            = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step_inc,
  input  logic                          step_dec,
  input  logic                          sel_btn,
  input  logic                          upd_ack,
  output logic                          upd_req,
  output logic [IDX_W-1:0]              upd_idx,
  output logic [PARAM_W-1:0]            upd_val,
  output logic [IDX_W-1:0]              sel_idx,
  output logic                          edit,
  output logic [NUM_PARAMS*PARAM_W-1:0] param_bus
);
  localparam logic [PARAM_W-1:0] PMAX_V = PARAM_W'(PMAX);

  logic [NUM_PARAMS-1:0][PARAM_W-1:0] param_q, param_d;
  logic [IDX_W-1:0]                   sel_idx_q, sel_idx_d;
  logic [IDX_W-1:0]                   upd_idx_q, upd_idx_d;
  logic [PARAM_W-1:0]                 upd_val_q, upd_val_d;
  mode_e                              mode_q, mode_d;
  hs_e                                hs_q, hs_d;
  logic                               dirty_q, dirty_d;
  logic                               started_q;
  logic                               press, do_inc, do_dec, changed;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(sel_btn),
    .press  (press)
  );

  always_comb begin
    do_inc    = step_inc & ~step_dec & ~press;
    do_dec    = step_dec & ~step_inc & ~press;
    param_d   = param_q;
    sel_idx_d = sel_idx_q;
    mode_d    = mode_q;
    changed   = 1'b0;

    if (press) begin
      mode_d  = (mode_q == MODE_BROWSE) ? MODE_EDIT : MODE_BROWSE;
      changed = 1'b1;
    end else if (do_inc || do_dec) begin
      changed = 1'b1;
      if (mode_q == MODE_BROWSE) begin
        sel_idx_d = do_inc ? sel_idx_q + 1'b1 : sel_idx_q - 1'b1;
      end else if (do_inc) begin
        param_d[sel_idx_q] = (param_q[sel_idx_q] == PMAX_V) ? '0 : param_q[sel_idx_q] + 1'b1;
      end else begin
        param_d[sel_idx_q] = (param_q[sel_idx_q] == '0) ? PMAX_V : param_q[sel_idx_q] - 1'b1;
      end
    end

    hs_d      = hs_q;
    upd_idx_d = upd_idx_q;
    upd_val_d = upd_val_q;
    dirty_d   = dirty_q | changed;

    // A change landing on the launch edge stays pending for the next request.
    case (hs_q)
      HS_IDLE: begin
        if (started_q && dirty_q) begin
          hs_d      = HS_REQ;
          upd_idx_d = sel_idx_q;
          upd_val_d = param_q[sel_idx_q];
          dirty_d   = changed;
        end
      end
      HS_REQ: begin
        if (upd_ack) hs_d = HS_IDLE;
      end
      default: hs_d = HS_IDLE;
    endcase
  end

  // started_q holds off the post-reset request until the second edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      param_q   <= '0;
      sel_idx_q <= '0;
      upd_idx_q <= '0;
      upd_val_q <= '0;
      mode_q    <= MODE_BROWSE;
      hs_q      <= HS_IDLE;
      dirty_q   <= 1'b1;
      started_q <= 1'b0;
    end else begin
      param_q   <= param_d;
      sel_idx_q <= sel_idx_d;
      upd_idx_q <= upd_idx_d;
      upd_val_q <= upd_val_d;
      mode_q    <= mode_d;
      hs_q      <= hs_d;
      dirty_q   <= dirty_d;
      started_q <= 1'b1;
    end
  end

  assign upd_req   = (hs_q == HS_REQ);
  assign upd_idx   = upd_idx_q;
  assign upd_val   = upd_val_q;
  assign sel_idx   = sel_idx_q;
  assign edit      = (mode_q == MODE_EDIT);
  assign param_bus = param_q;
endmodule

// File: tb/tb_enc_param_ctrl.sv
// Directed bench for enc_param_ctrl: reset, browse, debounced press, edit wrap, handshake, mid-request reset.
module tb_enc_param_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_inc = 1'b0;
  logic        step_dec = 1'b0;
  logic        sel_btn = 1'b0;
  logic        upd_ack = 1'b0;
  logic        upd_req;
  logic [1:0]  upd_idx;
  logic [4:0]  upd_val;
  logic [1:0]  sel_idx;
  logic        edit;
  logic [19:0] param_bus;

  int          errors = 0;
  int          checks = 0;
  int          req_count = 0;
  int          edit_rises = 0;
  int          base = 0;
  logic        prev_req = 1'b0;
  logic        prev_edit = 1'b0;
  logic        auto_ack = 1'b0;
  logic [1:0]  last_idx = '0;
  logic [4:0]  last_val = '0;
  logic [1:0]  exp_sel [5];
  logic [4:0]  exp_dec [3];

  enc_param_ctrl #(.DEBOUNCE_CYCLES(16), .PMAX(19)) dut (
    .clk      (clk),
    .rst      (rst),
    .step_inc (step_inc),
    .step_dec (step_dec),
    .sel_btn  (sel_btn),
    .upd_ack  (upd_ack),
    .upd_req  (upd_req),
    .upd_idx  (upd_idx),
    .upd_val  (upd_val),
    .sel_idx  (sel_idx),
    .edit     (edit),
    .param_bus(param_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, track request/edit rises.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (upd_req && !prev_req) begin
      req_count++;
      last_idx = upd_idx;
      last_val = upd_val;
    end
    prev_req = upd_req;
    if (edit && !prev_edit) edit_rises++;
    prev_edit = edit;
    if (auto_ack) upd_ack = upd_req;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0; exp_sel[4] = 2'd1;
    exp_dec[0] = 5'd19; exp_dec[1] = 5'd18; exp_dec[2] = 5'd17;

    // Reset state, asserted between clock edges
    #2 rst = 1'b1;
    #1;
    chk("rst_upd_req", 32'(upd_req), 32'd0);
    chk("rst_sel_idx", 32'(sel_idx), 32'd0);
    chk("rst_edit", 32'(edit), 32'd0);
    chk("rst_param_bus", 32'(param_bus), 32'd0);
    chk("rst_upd_idx", 32'(upd_idx), 32'd0);
    chk("rst_upd_val", 32'(upd_val), 32'd0);
    repeat (3) cyc();

    // Release: request appears on the second edge, echoed ack retires it
    rst = 1'b0;
    auto_ack = 1'b1;
    base = req_count;
    cyc();
    chk("rel_edge1_req", 32'(upd_req), 32'd0);
    cyc();
    chk("rel_edge2_req", 32'(upd_req), 32'd1);
    chk("rel_edge2_idx", 32'(upd_idx), 32'd0);
    chk("rel_edge2_val", 32'(upd_val), 32'd0);
    repeat (6) cyc();
    chk("rel_req_low", 32'(upd_req), 32'd0);
    chk("rel_req_count", 32'(req_count - base), 32'd1);

    // Browse: five increments with wrap
    base = req_count;
    for (int k = 0; k < 5; k++) begin
      step_inc = 1'b1;
      cyc();
      step_inc = 1'b0;
      chk("browse_sel", 32'(sel_idx), 32'(exp_sel[k]));
      repeat (3) cyc();
    end
    repeat (2) cyc();
    chk("browse_req_count", 32'(req_count - base), 32'd5);
    chk("browse_last_idx", 32'(last_idx), 32'd1);
    chk("browse_last_val", 32'(last_val), 32'd0);
    chk("browse_edit", 32'(edit), 32'd0);

    // Bouncing button: short bursts must not be accepted
    base = edit_rises;
    for (int b = 0; b < 3; b++) begin
      sel_btn = 1'b1;
      repeat (5) cyc();
      sel_btn = 1'b0;
      repeat (5) cyc();
    end
    chk("bounce_no_edit", 32'(edit), 32'd0);
    sel_btn = 1'b1;
    repeat (30) cyc();
    chk("press_edit", 32'(edit), 32'd1);
    chk("press_once", 32'(edit_rises - base), 32'd1);
    chk("press_req_idx", 32'(last_idx), 32'd1);

    // Edit param 1 downward through the 0 -> PMAX wrap
    for (int k = 0; k < 3; k++) begin
      step_dec = 1'b1;
      cyc();
      step_dec = 1'b0;
      chk("edit_dec_val", 32'(param_bus[9:5]), 32'(exp_dec[k]));
      repeat (3) cyc();
    end
    chk("edit_dec_last_val", 32'(last_val), 32'd17);
    chk("edit_dec_last_idx", 32'(last_idx), 32'd1);
    chk("edit_others_lo", 32'(param_bus[4:0]), 32'd0);
    chk("edit_others_hi", 32'(param_bus[19:10]), 32'd0);
    chk("edit_sel_unchanged", 32'(sel_idx), 32'd1);

    // PMAX -> 0 wrap, then simultaneous steps are a no-op
    step_inc = 1'b1; cyc(); step_inc = 1'b0;
    chk("inc_18", 32'(param_bus[9:5]), 32'd18);
    repeat (3) cyc();
    step_inc = 1'b1; cyc(); step_inc = 1'b0;
    chk("inc_19", 32'(param_bus[9:5]), 32'd19);
    repeat (3) cyc();
    step_inc = 1'b1; cyc(); step_inc = 1'b0;
    chk("inc_wrap_0", 32'(param_bus[9:5]), 32'd0);
    repeat (3) cyc();
    chk("inc_wrap_req_val", 32'(last_val), 32'd0);
    base = req_count;
    step_inc = 1'b1; step_dec = 1'b1;
    cyc();
    step_inc = 1'b0; step_dec = 1'b0;
    chk("both_val", 32'(param_bus[9:5]), 32'd0);
    repeat (5) cyc();
    chk("both_no_req", 32'(req_count - base), 32'd0);
    chk("both_req_low", 32'(upd_req), 32'd0);

    // Ack while idle is ignored
    auto_ack = 1'b0;
    upd_ack = 1'b1;
    repeat (3) cyc();
    upd_ack = 1'b0;
    chk("idle_ack_ignored", 32'(req_count - base), 32'd0);

    // Held request stays stable while steps accumulate
    base = req_count;
    step_inc = 1'b1; cyc(); step_inc = 1'b0;
    cyc();
    chk("hold_req_start", 32'(upd_req), 32'd1);
    chk("hold_val_start", 32'(upd_val), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step_inc = (i == 2 || i == 5 || i == 8 || i == 11);
      cyc();
      step_inc = 1'b0;
      chk("hold_req", 32'(upd_req), 32'd1);
      chk("hold_idx", 32'(upd_idx), 32'd1);
      chk("hold_val", 32'(upd_val), 32'd1);
    end
    chk("hold_param", 32'(param_bus[9:5]), 32'd5);
    upd_ack = 1'b1; cyc(); upd_ack = 1'b0;
    chk("hold_ack_drop", 32'(upd_req), 32'd0);
    cyc();
    chk("follow_req", 32'(upd_req), 32'd1);
    chk("follow_idx", 32'(upd_idx), 32'd1);
    chk("follow_val", 32'(upd_val), 32'd5);
    upd_ack = 1'b1; cyc(); upd_ack = 1'b0;
    chk("follow_drop", 32'(upd_req), 32'd0);
    repeat (5) cyc();
    chk("follow_count", 32'(req_count - base), 32'd2);
    chk("follow_quiet", 32'(upd_req), 32'd0);

    // Reset in the middle of a request
    step_dec = 1'b1; cyc(); step_dec = 1'b0;
    cyc();
    chk("mid_req_high", 32'(upd_req), 32'd1);
    chk("mid_req_val", 32'(upd_val), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("async_upd_req", 32'(upd_req), 32'd0);
    chk("async_param_bus", 32'(param_bus), 32'd0);
    chk("async_sel_idx", 32'(sel_idx), 32'd0);
    chk("async_edit", 32'(edit), 32'd0);
    chk("async_upd_val", 32'(upd_val), 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    sel_btn = 1'b0;
    auto_ack = 1'b1;
    base = req_count;
    cyc();
    chk("rel2_edge1_req", 32'(upd_req), 32'd0);
    cyc();
    chk("rel2_edge2_req", 32'(upd_req), 32'd1);
    chk("rel2_edge2_idx", 32'(upd_idx), 32'd0);
    chk("rel2_edge2_val", 32'(upd_val), 32'd0);
    repeat (4) cyc();
    chk("rel2_req_low", 32'(upd_req), 32'd0);
    chk("rel2_req_count", 32'(req_count - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
